// File: rtl/fp_control_unit_if.sv
// fp_control_unit_if
//   Groups the issue-side handshake and the datapath select bus of the
//   FP add/sub/mult sequencer.
//   master : FP issue logic / datapath side (drives start, op_in, expDiff, carry)
//   slave  : fp_control_unit (drives busy, done and every datapath select)
//   Build option FPCTRL_BYPASS_EN adds the 1-bit bypass select.
interface fp_control_unit_if;
    logic       start;
    logic [1:0] op_in;
    logic [7:0] expDiff;
    logic       carry;
    logic       busy;
    logic       done;
    logic       smallerExpSrc;
    logic [7:0] shiftRightQtt;
    logic [1:0] operation;
    logic       normalization_src;
    logic       shift_src;
    logic [2:0] renorm_cnt;
`ifdef FPCTRL_BYPASS_EN
    logic       bypass;
`endif

    modport master (
        output start, op_in, expDiff, carry,
`ifdef FPCTRL_BYPASS_EN
        input  bypass,
`endif
        input  busy, done, smallerExpSrc, shiftRightQtt, operation,
               normalization_src, shift_src, renorm_cnt
    );

    modport slave (
        input  start, op_in, expDiff, carry,
`ifdef FPCTRL_BYPASS_EN
        output bypass,
`endif
        output busy, done, smallerExpSrc, shiftRightQtt, operation,
               normalization_src, shift_src, renorm_cnt
    );
endinterface

// File: rtl/fp_control_unit.sv
// fp_control_unit
//   Multi-cycle sequencer for the single-precision FP add/sub/mult datapath.
//   One op per start/done handshake: ALIGN -> EXEC -> NORM -> CHECK -> DONE,
//   with NORM/CHECK repeated while the rounded fraction carries out (at most
//   MAX_RENORM re-passes). All outputs are registered.
// Ports
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; drops any in-flight op without done
//   bus   : fp_control_unit_if.slave (start/op_in/expDiff/carry in;
//           busy/done and datapath selects out)
// Parameters
//   MAX_RENORM : max normalize/round re-passes before forcing DONE (1..7)
//   FRAC_W     : datapath fraction width; alignment shift saturates here
// Build option
//   FPCTRL_BYPASS_EN : add/sub whose |expDiff| exceeds FRAC_W skips the big
//                      ALU and finishes in 3 cycles with bypass=1.
module fp_control_unit #(
    parameter int unsigned MAX_RENORM = 2,
    parameter int unsigned FRAC_W     = 27
) (
    input logic              clk,
    input logic              reset,
    fp_control_unit_if.slave bus
);
    localparam logic [7:0] FRAC_SAT = 8'(FRAC_W);
    localparam logic [2:0] MAX_CNT  = 3'(MAX_RENORM);

    typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, CHECK, DONE} state_t;

    state_t     state, nState;
    logic       busyQ, nBusy;
    logic       doneQ, nDone;
    logic       smallerQ, nSmaller;
    logic [7:0] shiftQtyQ, nShiftQty;
    logic [1:0] opQ, nOp;
    logic       normSrcQ, nNormSrc;
    logic       shiftSrcQ, nShiftSrc;
    logic [2:0] cntQ, nCnt;
`ifdef FPCTRL_BYPASS_EN
    logic       bypassQ, nBypass;
`endif

    logic [7:0] expMag;
    logic       tooFar;

    // 8'h80 negates to 8'h80, read unsigned as 128, so it saturates correctly.
    always_comb begin
        expMag = bus.expDiff[7] ? (~bus.expDiff + 8'd1) : bus.expDiff;
        tooFar = (expMag > FRAC_SAT);
    end

    always_comb begin
        nState    = state;
        nBusy     = busyQ;
        nSmaller  = smallerQ;
        nShiftQty = shiftQtyQ;
        nOp       = opQ;
        nNormSrc  = normSrcQ;
        nShiftSrc = shiftSrcQ;
        nCnt      = cntQ;
`ifdef FPCTRL_BYPASS_EN
        nBypass   = bypassQ;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nOp    = bus.op_in;
                    nBusy  = 1'b1;
                    nCnt   = '0;
`ifdef FPCTRL_BYPASS_EN
                    nBypass = 1'b0;
`endif
                    nState = ALIGN;
                end
            end
            ALIGN: begin
                nSmaller  = ~bus.expDiff[7];
                nShiftQty = tooFar ? FRAC_SAT : expMag;
                if (opQ == 2'b10) begin
                    nShiftQty = '0;
                end
`ifdef FPCTRL_BYPASS_EN
                // Flag is consumed in EXEC so the bypassed op still takes 3 cycles.
                if (opQ != 2'b10 && tooFar) begin
                    nBypass = 1'b1;
                end
`endif
                nState = EXEC;
            end
            EXEC: begin
                nNormSrc = 1'b1;
                nState   = NORM;
`ifdef FPCTRL_BYPASS_EN
                if (bypassQ) begin
                    nState = DONE;
                end
`endif
            end
            NORM: begin
                nShiftSrc = bus.carry;
                nState    = CHECK;
            end
            CHECK: begin
                nNormSrc = 1'b0;
                if (bus.carry && cntQ < MAX_CNT) begin
                    nCnt      = cntQ + 3'd1;
                    nShiftSrc = 1'b1;
                    nState    = NORM;
                end else begin
                    nState = DONE;
                end
            end
            DONE: begin
                nBusy  = 1'b0;
                nState = IDLE;
            end
            default: nState = IDLE;
        endcase
        // done is high for exactly the cycle spent in DONE.
        nDone = (nState == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
            smallerQ  <= 1'b0;
            shiftQtyQ <= '0;
            opQ       <= '0;
            normSrcQ  <= 1'b1;
            shiftSrcQ <= 1'b0;
            cntQ      <= '0;
`ifdef FPCTRL_BYPASS_EN
            bypassQ   <= 1'b0;
`endif
        end else begin
            state     <= nState;
            busyQ     <= nBusy;
            doneQ     <= nDone;
            smallerQ  <= nSmaller;
            shiftQtyQ <= nShiftQty;
            opQ       <= nOp;
            normSrcQ  <= nNormSrc;
            shiftSrcQ <= nShiftSrc;
            cntQ      <= nCnt;
`ifdef FPCTRL_BYPASS_EN
            bypassQ   <= nBypass;
`endif
        end
    end

    assign bus.busy              = busyQ;
    assign bus.done              = doneQ;
    assign bus.smallerExpSrc     = smallerQ;
    assign bus.shiftRightQtt     = shiftQtyQ;
    assign bus.operation         = opQ;
    assign bus.normalization_src = normSrcQ;
    assign bus.shift_src         = shiftSrcQ;
    assign bus.renorm_cnt        = cntQ;
`ifdef FPCTRL_BYPASS_EN
    assign bus.bypass            = bypassQ;
`endif
endmodule

// File: tb/tb_fp_control_unit.sv
// tb_fp_control_unit
//   Directed bench for fp_control_unit (MAX_RENORM=2, FRAC_W=27).
//   Honours FPCTRL_BYPASS_EN when defined.
module tb_fp_control_unit;
    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;

    fp_control_unit_if bus ();

    fp_control_unit #(.MAX_RENORM(2), .FRAC_W(27)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one op from IDLE. lat = edges from the accepting edge to the
    // first cycle with done=1 (bounded); pulses = done cycles seen including
    // four cycles after the first one.
    task automatic runOp(input logic [1:0] op, input logic [7:0] ed, input logic cr,
                         output int lat, output int pulses);
        bus.op_in   = op;
        bus.expDiff = ed;
        bus.carry   = cr;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        lat    = 1;
        pulses = bus.done ? 1 : 0;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
        end
        pulses = bus.done ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done) pulses++;
        end
    endtask

    int  lat;
    int  pulses;
    int  doneSeen;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op_in   = 2'b00;
        bus.expDiff = 8'h00;
        bus.carry   = 1'b0;
        step();
        step();

        // Reset state
        check("rst_busy",    bus.busy, 0);
        check("rst_done",    bus.done, 0);
        check("rst_smaller", bus.smallerExpSrc, 0);
        check("rst_shift",   bus.shiftRightQtt, 0);
        check("rst_op",      bus.operation, 0);
        check("rst_normsrc", bus.normalization_src, 1);
        check("rst_shsrc",   bus.shift_src, 0);
        check("rst_cnt",     bus.renorm_cnt, 0);
`ifdef FPCTRL_BYPASS_EN
        check("rst_bypass",  bus.bypass, 0);
`endif
        reset = 1'b0;
        step();

        // T1: reset while in NORM drops the op
        bus.op_in   = 2'b01;
        bus.expDiff = 8'hFB;
        bus.carry   = 1'b1;
        bus.start   = 1'b1;
        step();                    // ALIGN
        bus.start = 1'b0;
        check("t1_busy_on", bus.busy, 1);
        step();                    // EXEC
        check("t1_shift_mid", bus.shiftRightQtt, 5);
        step();                    // NORM
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t1_busy",    bus.busy, 0);
        check("t1_done",    bus.done, 0);
        check("t1_shift",   bus.shiftRightQtt, 0);
        check("t1_op",      bus.operation, 0);
        check("t1_normsrc", bus.normalization_src, 1);
        check("t1_shsrc",   bus.shift_src, 0);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done) doneSeen++;
        end
        check("t1_no_done", doneSeen, 0);
        check("t1_idle_busy", bus.busy, 0);

        // T2: add, expDiff=+3
        runOp(2'b00, 8'h03, 1'b0, lat, pulses);
        check("t2_lat",     lat, 5);
        check("t2_pulses",  pulses, 1);
        check("t2_smaller", bus.smallerExpSrc, 1);
        check("t2_shift",   bus.shiftRightQtt, 3);
        check("t2_op",      bus.operation, 0);
        check("t2_cnt",     bus.renorm_cnt, 0);
        check("t2_shsrc",   bus.shift_src, 0);
        check("t2_normsrc", bus.normalization_src, 0);
        check("t2_busy",    bus.busy, 0);

        // T3: sub, expDiff=-5
        runOp(2'b01, 8'hFB, 1'b0, lat, pulses);
        check("t3_lat",     lat, 5);
        check("t3_smaller", bus.smallerExpSrc, 0);
        check("t3_shift",   bus.shiftRightQtt, 5);
        check("t3_op",      bus.operation, 1);

        // T4: carry always set, re-passes capped at 2
        runOp(2'b00, 8'h00, 1'b1, lat, pulses);
        check("t4_lat",     lat, 9);
        check("t4_pulses",  pulses, 1);
        check("t4_shsrc",   bus.shift_src, 1);
        check("t4_cnt",     bus.renorm_cnt, 2);
        check("t4_smaller", bus.smallerExpSrc, 1);
        check("t4_shift",   bus.shiftRightQtt, 0);

        // T5: mult ignores alignment; far add saturates (or bypasses)
        runOp(2'b10, 8'h40, 1'b0, lat, pulses);
        check("t5m_lat",   lat, 5);
        check("t5m_shift", bus.shiftRightQtt, 0);
        check("t5m_op",    bus.operation, 2);
        check("t5m_cnt",   bus.renorm_cnt, 0);
        runOp(2'b00, 8'h40, 1'b0, lat, pulses);
        check("t5a_shift", bus.shiftRightQtt, 27);
`ifdef FPCTRL_BYPASS_EN
        check("t5a_lat",    lat, 3);
        check("t5a_bypass", bus.bypass, 1);
`else
        check("t5a_lat",    lat, 5);
`endif
        runOp(2'b11, 8'h80, 1'b0, lat, pulses);
        check("t5n_shift",   bus.shiftRightQtt, 27);
        check("t5n_smaller", bus.smallerExpSrc, 0);
        check("t5n_op",      bus.operation, 3);
        runOp(2'b01, 8'hE5, 1'b0, lat, pulses);   // -27: boundary, not beyond
        check("t5b_lat",     lat, 5);
        check("t5b_shift",   bus.shiftRightQtt, 27);
        check("t5b_smaller", bus.smallerExpSrc, 0);
`ifdef FPCTRL_BYPASS_EN
        check("t5b_bypass",  bus.bypass, 0);
`endif
        runOp(2'b00, 8'h1C, 1'b0, lat, pulses);   // +28: just beyond
        check("t5c_shift",   bus.shiftRightQtt, 27);
        check("t5c_smaller", bus.smallerExpSrc, 1);

        // T6: start held high, ops chain 6 cycles apart
        bus.op_in   = 2'b00;
        bus.expDiff = 8'h03;
        bus.carry   = 1'b0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) bus.op_in = 2'b01;
            check($sformatf("t6_done_c%0d", c), bus.done, (c == 5 || c == 11 || c == 17) ? 1 : 0);
            if (c == 5) check("t6_op_first", bus.operation, 0);
            if (c == 6) check("t6_gap_busy", bus.busy, 0);
            if (c == 7) begin
                check("t6_op_second", bus.operation, 1);
                check("t6_busy2", bus.busy, 1);
            end
        end
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t6_final_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
